// File: rtl/counter_param.sv
// counter_param: parameterised up/down counter with a run-time modulo limit,
// a programmable step, wrap or saturate behaviour at the bounds, registered
// overflow/underflow pulses, sticky flags with clear, and a terminal-count
// output.
//
// Arithmetic is done one bit wider than the counter, so cnt + step never
// loses its carry and cnt + (limit + 1) cannot overflow when limit is all-ones.
// The counter is kept in [0..limit] by construction. If limit_in is lowered
// below the current count, the next enabled count recovers the range in
// either direction.

module counter_param #(
    parameter int WIDTH     = 8,
    parameter int STEP_W    = 4,
    parameter int RESET_VAL = 0
) (
    input  logic              clk_in,
    input  logic              nrst_in,
    input  logic              en_ctrl_in,
    input  logic              set_ctrl_in,
    input  logic              up_ctrl_in,
    input  logic              sat_ctrl_in,
    input  logic [WIDTH-1:0]  counter_in,
    input  logic [WIDTH-1:0]  limit_in,
    input  logic [STEP_W-1:0] step_in,
    input  logic              clr_flags_in,
    output logic [WIDTH-1:0]  counter_out,
    output logic              ovf_out,
    output logic              unf_out,
    output logic              ovf_sticky_out,
    output logic              unf_sticky_out,
    output logic              tc_out
);

    localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VAL);

    // Registered state
    logic [WIDTH-1:0] r_cnt;
    logic             r_ovf;
    logic             r_unf;
    logic             r_ovf_sticky;
    logic             r_unf_sticky;

    // Widened operands: one extra bit so carries and limit+1 are exact
    logic [WIDTH:0]   w_cnt_ext;
    logic [WIDTH:0]   w_lim_ext;
    logic [WIDTH:0]   w_lim_p1;
    logic [WIDTH:0]   w_step_ext;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_wrap_up;
    logic [WIDTH:0]   w_wrap_dn;
    logic             w_above;
    logic             w_step_zero;
    logic [WIDTH-1:0] w_load_val;

    // Next-state values
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_ovf_nxt;
    logic             w_unf_nxt;
    logic             w_ovf_sticky_nxt;
    logic             w_unf_sticky_nxt;

    assign w_cnt_ext   = {1'b0, r_cnt};
    assign w_lim_ext   = {1'b0, limit_in};
    assign w_lim_p1    = w_lim_ext + 1'b1;
    assign w_step_ext  = (WIDTH+1)'(step_in);
    assign w_sum       = w_cnt_ext + w_step_ext;
    // Wrap results stay within [0..limit] for any legal step. An illegal step
    // just gives a truncated value and cannot stall the counter.
    assign w_wrap_up   = w_sum - w_lim_p1;
    assign w_wrap_dn   = w_cnt_ext + w_lim_p1 - w_step_ext;
    assign w_above     = r_cnt > limit_in;
    assign w_step_zero = (step_in == '0);
    assign w_load_val  = (counter_in < limit_in) ? counter_in : limit_in;

    // Next count and pulse decode: set > enabled count > hold
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned infers a latch.
        w_cnt_nxt = r_cnt;
        w_ovf_nxt = 1'b0;
        w_unf_nxt = 1'b0;

        if (set_ctrl_in) begin
            w_cnt_nxt = w_load_val;
        end else if (en_ctrl_in && !w_step_zero) begin
            if (w_above) begin
                // Limit was lowered below the count: pull back into range
                w_cnt_nxt = sat_ctrl_in ? limit_in : '0;
                w_ovf_nxt = 1'b1;
            end else if (up_ctrl_in) begin
                if (w_sum > w_lim_ext) begin
                    w_cnt_nxt = sat_ctrl_in ? limit_in : WIDTH'(w_wrap_up);
                    w_ovf_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = WIDTH'(w_sum);
                end
            end else begin
                if (w_cnt_ext >= w_step_ext) begin
                    w_cnt_nxt = WIDTH'(w_cnt_ext - w_step_ext);
                end else begin
                    w_cnt_nxt = sat_ctrl_in ? '0 : WIDTH'(w_wrap_dn);
                    w_unf_nxt = 1'b1;
                end
            end
        end
    end

    // Sticky flags: a new event wins over a clear in the same cycle
    always_comb begin
        w_ovf_sticky_nxt = w_ovf_nxt | (r_ovf_sticky & ~clr_flags_in);
        w_unf_sticky_nxt = w_unf_nxt | (r_unf_sticky & ~clr_flags_in);
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            r_cnt        <= RST_CNT;
            r_ovf        <= 1'b0;
            r_unf        <= 1'b0;
            r_ovf_sticky <= 1'b0;
            r_unf_sticky <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, whatever the statement order.
            r_cnt        <= w_cnt_nxt;
            r_ovf        <= w_ovf_nxt;
            r_unf        <= w_unf_nxt;
            r_ovf_sticky <= w_ovf_sticky_nxt;
            r_unf_sticky <= w_unf_sticky_nxt;
        end
    end

    assign counter_out    = r_cnt;
    assign ovf_out        = r_ovf;
    assign unf_out        = r_unf;
    assign ovf_sticky_out = r_ovf_sticky;
    assign unf_sticky_out = r_unf_sticky;

    // Terminal count is combinational and is forced low while the count is above the limit
    assign tc_out = ~w_above & (up_ctrl_in ? (r_cnt == limit_in) : (r_cnt == '0));

endmodule

// File: tb/tb_counter_param.sv
// Directed testbench for counter_param (WIDTH=8, STEP_W=4, RESET_VAL=0).
// Inputs change 1 time unit after a rising edge. Outputs are checked at
// that point, after the edge has taken effect.

module tb_counter_param;

    logic       clk_in = 1'b0;
    logic       nrst_in;
    logic       en_ctrl_in;
    logic       set_ctrl_in;
    logic       up_ctrl_in;
    logic       sat_ctrl_in;
    logic [7:0] counter_in;
    logic [7:0] limit_in;
    logic [3:0] step_in;
    logic       clr_flags_in;
    logic [7:0] counter_out;
    logic       ovf_out;
    logic       unf_out;
    logic       ovf_sticky_out;
    logic       unf_sticky_out;
    logic       tc_out;

    int n_checks = 0;
    int n_pass   = 0;

    counter_param #(
        .WIDTH     (8),
        .STEP_W    (4),
        .RESET_VAL (0)
    ) dut (
        .clk_in         (clk_in),
        .nrst_in        (nrst_in),
        .en_ctrl_in     (en_ctrl_in),
        .set_ctrl_in    (set_ctrl_in),
        .up_ctrl_in     (up_ctrl_in),
        .sat_ctrl_in    (sat_ctrl_in),
        .counter_in     (counter_in),
        .limit_in       (limit_in),
        .step_in        (step_in),
        .clr_flags_in   (clr_flags_in),
        .counter_out    (counter_out),
        .ovf_out        (ovf_out),
        .unf_out        (unf_out),
        .ovf_sticky_out (ovf_sticky_out),
        .unf_sticky_out (unf_sticky_out),
        .tc_out         (tc_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Check count and both pulses in one call
    task automatic check_cnt(input string tag, input logic [7:0] cnt, input logic ovf, input logic unf);
        check({tag, ".cnt"}, 32'(counter_out), 32'(cnt));
        check({tag, ".ovf"}, 32'(ovf_out), 32'(ovf));
        check({tag, ".unf"}, 32'(unf_out), 32'(unf));
    endtask

    initial begin
        nrst_in      = 1'b1;
        en_ctrl_in   = 1'b0;
        set_ctrl_in  = 1'b0;
        up_ctrl_in   = 1'b1;
        sat_ctrl_in  = 1'b0;
        counter_in   = 8'h00;
        limit_in     = 8'hFF;
        step_in      = 4'd1;
        clr_flags_in = 1'b0;

        // Reset state
        #1 nrst_in = 1'b0;
        #2;
        check_cnt("rst", 8'h00, 1'b0, 1'b0);
        check("rst.ovf_sticky", 32'(ovf_sticky_out), 0);
        check("rst.unf_sticky", 32'(unf_sticky_out), 0);
        check("rst.tc", 32'(tc_out), 0);
        #4 nrst_in = 1'b1;
        tick();

        // Full-range wrap: limit 0xFF, step 1, up from 0xFE
        set_ctrl_in = 1'b1; counter_in = 8'hFE;
        tick();
        check_cnt("fr.load", 8'hFE, 1'b0, 1'b0);
        set_ctrl_in = 1'b0; en_ctrl_in = 1'b1;
        tick();
        check_cnt("fr.ff", 8'hFF, 1'b0, 1'b0);
        check("fr.tc_ff", 32'(tc_out), 1);
        tick();
        check_cnt("fr.wrap", 8'h00, 1'b1, 1'b0);
        check("fr.ovf_sticky", 32'(ovf_sticky_out), 1);
        check("fr.tc_00", 32'(tc_out), 0);
        tick();
        check_cnt("fr.after", 8'h01, 1'b0, 1'b0);
        check("fr.ovf_sticky_hold", 32'(ovf_sticky_out), 1);

        // Reset mid-count: load 0x20, count to 0x25, reset between edges
        set_ctrl_in = 1'b1; counter_in = 8'h20;
        tick();
        set_ctrl_in = 1'b0;
        repeat (5) tick();
        check_cnt("mid.cnt25", 8'h25, 1'b0, 1'b0);
        #3 nrst_in = 1'b0;
        #1;
        check_cnt("mid.rst", 8'h00, 1'b0, 1'b0);
        check("mid.rst_ovf_sticky", 32'(ovf_sticky_out), 0);
        check("mid.rst_unf_sticky", 32'(unf_sticky_out), 0);
        en_ctrl_in = 1'b0;
        #1 nrst_in = 1'b1;
        tick();
        check_cnt("mid.release", 8'h00, 1'b0, 1'b0);

        // Modulo wrap: limit 9, step 3, up from 0 -> 3, 6, 9, 2
        limit_in = 8'd9; step_in = 4'd3;
        set_ctrl_in = 1'b1; counter_in = 8'd0;
        tick();
        set_ctrl_in = 1'b0; en_ctrl_in = 1'b1;
        tick(); check_cnt("mod.3", 8'd3, 1'b0, 1'b0);
        tick(); check_cnt("mod.6", 8'd6, 1'b0, 1'b0);
        tick(); check_cnt("mod.9", 8'd9, 1'b0, 1'b0);
        check("mod.tc9", 32'(tc_out), 1);
        check("mod.sticky_pre", 32'(ovf_sticky_out), 0);
        tick(); check_cnt("mod.2", 8'd2, 1'b1, 1'b0);
        check("mod.sticky", 32'(ovf_sticky_out), 1);

        // Step 0 holds and raises no flags
        step_in = 4'd0;
        tick(); check_cnt("hold", 8'd2, 1'b0, 1'b0);

        // Saturate down: limit 9, step 4, from 5 -> 1, 0 (unf), 0 (unf)
        step_in = 4'd4; up_ctrl_in = 1'b0; sat_ctrl_in = 1'b1;
        en_ctrl_in = 1'b0; set_ctrl_in = 1'b1; counter_in = 8'd5;
        tick();
        check_cnt("sat.load", 8'd5, 1'b0, 1'b0);
        set_ctrl_in = 1'b0; en_ctrl_in = 1'b1;
        tick(); check_cnt("sat.1", 8'd1, 1'b0, 1'b0);
        check("sat.unf_sticky_pre", 32'(unf_sticky_out), 0);
        tick(); check_cnt("sat.0a", 8'd0, 1'b0, 1'b1);
        check("sat.tc0", 32'(tc_out), 1);
        tick(); check_cnt("sat.0b", 8'd0, 1'b0, 1'b1);
        check("sat.unf_sticky", 32'(unf_sticky_out), 1);

        // Set priority: set and en together, load clamped to limit
        up_ctrl_in = 1'b1; sat_ctrl_in = 1'b0; step_in = 4'd1;
        set_ctrl_in = 1'b1; counter_in = 8'h40; limit_in = 8'h30;
        tick();
        check_cnt("set.clamp", 8'h30, 1'b0, 1'b0);
        check("set.ovf_sticky", 32'(ovf_sticky_out), 1);
        check("set.unf_sticky", 32'(unf_sticky_out), 1);

        // Flag collision: clear with an ovf event in the same cycle
        set_ctrl_in = 1'b0; clr_flags_in = 1'b1;
        tick();
        check_cnt("col.wrap", 8'h00, 1'b1, 1'b0);
        check("col.ovf_sticky", 32'(ovf_sticky_out), 1);
        check("col.unf_sticky", 32'(unf_sticky_out), 0);
        en_ctrl_in = 1'b0;
        tick();
        check("col.clr_ovf_sticky", 32'(ovf_sticky_out), 0);
        check("col.clr_ovf", 32'(ovf_out), 0);
        clr_flags_in = 1'b0;

        // Limit lowered below count: wrap mode, counting down -> 0 with ovf
        set_ctrl_in = 1'b1; counter_in = 8'h20;
        tick();
        set_ctrl_in = 1'b0; limit_in = 8'h10; up_ctrl_in = 1'b0;
        #1;
        check("low.tc", 32'(tc_out), 0);
        en_ctrl_in = 1'b1;
        tick();
        check_cnt("low.wrap", 8'h00, 1'b1, 1'b0);

        // Limit lowered below count: saturate mode, counting up -> limit with ovf
        en_ctrl_in = 1'b0; limit_in = 8'h30; set_ctrl_in = 1'b1;
        tick();
        set_ctrl_in = 1'b0; limit_in = 8'h10; sat_ctrl_in = 1'b1; up_ctrl_in = 1'b1;
        en_ctrl_in = 1'b1;
        tick();
        check_cnt("low.sat", 8'h10, 1'b1, 1'b0);
        // Saturate at the upper bound pulses again
        tick();
        check_cnt("sat.up_again", 8'h10, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
